// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared types for the round-robin FIFO drain scheduler.
package fifo_sched_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first requesting index strictly after
// last_grant, wrapping from NUM_SRC-1 back to 0.
module rr_pick
   import fifo_sched_pkg::*;
#(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0]         req,
   input  logic [$clog2(NUM_SRC)-1:0] last_grant,
   output logic                       found,
   output logic [$clog2(NUM_SRC)-1:0] idx
);

   localparam int SRC_W = $clog2(NUM_SRC);

   int               cand;
   logic [SRC_W-1:0] cand_idx;

   // Walk offsets 1..NUM_SRC so last_grant itself is considered last.
   always_comb begin
      found    = 1'b0;
      idx      = '0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         cand = int'(last_grant) + i;
         if (cand >= NUM_SRC) begin
            cand = cand - NUM_SRC;
         end
         cand_idx = SRC_W'(cand);
         if (!found && req[cand_idx]) begin
            found = 1'b1;
            idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin burst drain of NUM_SRC zero-latency FIFOs into one registered
// valid/ready stream. Define SCHED_STATS_EN to add per-source beat counters.
module fifo_rr_scheduler
   import fifo_sched_pkg::*;
#(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [NUM_SRC-1:0]            src_empty,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_dout,
   output logic [NUM_SRC-1:0]            src_shift_out,
   output logic [DATA_WIDTH-1:0]         m_data,
   output logic [$clog2(NUM_SRC)-1:0]    m_src,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          busy
`ifdef SCHED_STATS_EN
   ,
   output logic [NUM_SRC*STAT_W-1:0]     stat_beats,
   input  logic                          stat_clr
`endif
);

   localparam int SRC_W  = $clog2(NUM_SRC);
   localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

   state_t            state, state_next;
   logic [SRC_W-1:0]  grant, last_grant, pick_idx;
   logic [BEAT_W-1:0] beat_cnt;
   logic              pick_found, can_load, pop, burst_done;
   logic [DATA_WIDTH-1:0] head_word;

   rr_pick #(
      .NUM_SRC(NUM_SRC)
   ) u_pick (
      .req       (~src_empty),
      .last_grant(last_grant),
      .found     (pick_found),
      .idx       (pick_idx)
   );

   assign can_load = !m_valid || m_ready;
   assign busy     = (state == S_BURST);

   always_comb begin
      head_word = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant == SRC_W'(i)) begin
            head_word = src_dout[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Pops are gated by S_BURST so an async reset kills them in the same cycle.
   always_comb begin
      state_next    = state;
      pop           = 1'b0;
      burst_done    = 1'b0;
      src_shift_out = '0;
      if (state == S_BURST) begin
         pop                  = !src_empty[grant] && can_load;
         src_shift_out[grant] = pop;
         if ((pop && beat_cnt == BEAT_LAST) || (!pop && src_empty[grant])) begin
            burst_done = 1'b1;
            state_next = S_IDLE;
         end
      end else if (enable && pick_found) begin
         state_next = S_BURST;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A pop always reloads the output register, even while it is being consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant      <= '0;
         last_grant <= SRC_W'(NUM_SRC - 1);
         beat_cnt   <= '0;
         m_data     <= '0;
         m_src      <= '0;
         m_valid    <= 1'b0;
      end else begin
         if (state == S_IDLE) begin
            if (state_next == S_BURST) begin
               grant    <= pick_idx;
               beat_cnt <= '0;
            end
         end else if (burst_done) begin
            last_grant <= grant;
         end else if (pop) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
         end
         if (pop) begin
            m_data  <= head_word;
            m_src   <= grant;
            m_valid <= 1'b1;
         end else if (m_ready && m_valid) begin
            m_valid <= 1'b0;
         end
      end
   end

`ifdef SCHED_STATS_EN
   logic [STAT_W-1:0] stat_cnt [NUM_SRC];

   // Clear wins over a coincident pop; counters stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            stat_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (stat_clr) begin
               stat_cnt[i] <= '0;
            end else if (src_shift_out[i] && stat_cnt[i] != '1) begin
               stat_cnt[i] <= stat_cnt[i] + STAT_W'(1);
            end
         end
      end
   end

   always_comb begin
      stat_beats = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         stat_beats[i*STAT_W +: STAT_W] = stat_cnt[i];
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler with a small FIFO model per source.
// Build with SCHED_STATS_EN defined to also exercise the beat counters.
module tb_fifo_rr_scheduler;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         enable;
   logic [3:0]   src_empty;
   logic [127:0] src_dout;
   logic [3:0]   src_shift_out;
   logic [31:0]  m_data;
   logic [1:0]   m_src;
   logic         m_valid;
   logic         m_ready;
   logic         busy;
`ifdef SCHED_STATS_EN
   logic [63:0]  stat_beats;
   logic         stat_clr = 1'b0;
`endif

   int testsRun    = 0;
   int testsFailed = 0;

   bit [31:0] fifoMem [4][64];
   int        wrPtr [4];
   int        rdPtr [4];

   int          cycle = 0;
   int          rxCnt = 0;
   int          rxBase = 0;
   logic [31:0] rxData [256];
   logic [1:0]  rxSrc  [256];
   int          rxCyc  [256];

   fifo_rr_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .src_empty    (src_empty),
      .src_dout     (src_dout),
      .src_shift_out(src_shift_out),
      .m_data       (m_data),
      .m_src        (m_src),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .busy         (busy)
`ifdef SCHED_STATS_EN
      ,
      .stat_beats   (stat_beats),
      .stat_clr     (stat_clr)
`endif
   );

   always #5 clk = ~clk;

   always_comb begin
      src_empty = '0;
      src_dout  = '0;
      for (int i = 0; i < 4; i++) begin
         src_empty[i]          = (rdPtr[i] == wrPtr[i]);
         src_dout[i*32 +: 32]  = fifoMem[i][rdPtr[i][5:0]];
      end
   end

   always @(posedge clk) begin
      cycle <= cycle + 1;
      for (int i = 0; i < 4; i++) begin
         if (src_shift_out[i]) rdPtr[i] <= rdPtr[i] + 1;
      end
   end

   // Handshakes are logged mid-cycle, when inputs and outputs are both settled.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         rxData[rxCnt % 256] = m_data;
         rxSrc[rxCnt % 256]  = m_src;
         rxCyc[rxCnt % 256]  = cycle;
         rxCnt = rxCnt + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int src, input logic [31:0] data);
      fifoMem[src][wrPtr[src][5:0]] = data;
      wrPtr[src] = wrPtr[src] + 1;
   endtask

   task automatic doReset();
      rst_n   = 1'b0;
      enable  = 1'b1;
      m_ready = 1'b1;
      for (int s = 0; s < 4; s++) wrPtr[s] = rdPtr[s];
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      rxBase = rxCnt;
   endtask

   task automatic waitRx(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while ((rxCnt - rxBase) < n && k < budget) begin
         tick();
         k++;
      end
      checkOutput(tag, 64'(rxCnt - rxBase), 64'(n));
   endtask

   function automatic logic [33:0] rxAt(input int j);
      return {rxSrc[(rxBase + j) % 256], rxData[(rxBase + j) % 256]};
   endfunction

   initial begin
      rst_n   = 1'b0;
      enable  = 1'b1;
      m_ready = 1'b1;

      // Reset state
      tick();
      checkOutput("rst_valid", m_valid, 0);
      checkOutput("rst_data", m_data, 0);
      checkOutput("rst_src", m_src, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_pop", src_shift_out, 0);
      rst_n = 1'b1;
      tick();
      rxBase = rxCnt;

      // Single source, three words, early burst end
      applyStimulus(2, 32'hA000_000A);
      applyStimulus(2, 32'hB000_000B);
      applyStimulus(2, 32'hC000_000C);
      tick();
      checkOutput("single_busy", busy, 1);
      checkOutput("single_nv", m_valid, 0);
      checkOutput("single_pop", src_shift_out, 4'b0100);
      tick();
      checkOutput("single_A", {m_valid, m_src, m_data}, {1'b1, 2'd2, 32'hA000_000A});
      tick();
      checkOutput("single_B", {m_valid, m_src, m_data}, {1'b1, 2'd2, 32'hB000_000B});
      tick();
      checkOutput("single_C", {m_valid, m_src, m_data}, {1'b1, 2'd2, 32'hC000_000C});
      checkOutput("single_nopop", src_shift_out, 0);
      tick();
      checkOutput("single_idle", busy, 0);
      checkOutput("single_drain", m_valid, 0);

      // last_grant is now 2: source 3 must win over source 0
      rxBase = rxCnt;
      applyStimulus(0, 32'h0000_0F00);
      applyStimulus(3, 32'h0000_0F03);
      waitRx("lg_cnt", 2, 20);
      checkOutput("lg_first", rxAt(0), {2'd3, 32'h0000_0F03});
      checkOutput("lg_second", rxAt(1), {2'd0, 32'h0000_0F00});

      // Skip empties after reset, then wrap from 3 to 0
      doReset();
      applyStimulus(2, 32'h0000_2222);
      waitRx("skip_cnt", 1, 20);
      checkOutput("skip_src", rxAt(0), {2'd2, 32'h0000_2222});
      tick();
      tick();
      rxBase = rxCnt;
      applyStimulus(3, 32'h0000_3333);
      waitRx("w3_cnt", 1, 20);
      tick();
      tick();
      rxBase = rxCnt;
      applyStimulus(0, 32'h0000_0A0A);
      applyStimulus(3, 32'h0000_3B3B);
      waitRx("wrap_cnt", 2, 20);
      checkOutput("wrap_first", rxAt(0), {2'd0, 32'h0000_0A0A});
      checkOutput("wrap_second", rxAt(1), {2'd3, 32'h0000_3B3B});

      // All sources full: bursts of 4 with one bubble between bursts
      doReset();
      for (int s = 0; s < 4; s++)
         for (int k = 0; k < 8; k++)
            applyStimulus(s, 32'h100 * s + k);
      waitRx("rr_cnt", 32, 200);
      for (int j = 0; j < 32; j++) begin
         checkOutput($sformatf("rr_beat%0d", j), rxAt(j),
                     {2'((j / 4) % 4), 32'(32'h100 * ((j / 4) % 4) + (j / 16) * 4 + (j % 4))});
      end
      checkOutput("rr_back2back", 64'(rxCyc[(rxBase + 1) % 256] - rxCyc[rxBase % 256]), 1);
      checkOutput("rr_bubble", 64'(rxCyc[(rxBase + 4) % 256] - rxCyc[(rxBase + 3) % 256]), 2);
      checkOutput("rr_span", 64'(rxCyc[(rxBase + 31) % 256] - rxCyc[rxBase % 256]), 38);

      // Backpressure for five cycles mid-burst
      doReset();
      for (int k = 0; k < 4; k++) applyStimulus(1, 32'hD000_0000 + k);
      tick();
      tick();
      checkOutput("bp_first", {m_valid, m_data}, {1'b1, 32'hD000_0000});
      m_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput($sformatf("bp_hold%0d", k), {m_valid, m_data}, {1'b1, 32'hD000_0000});
         checkOutput($sformatf("bp_nopop%0d", k), src_shift_out, 0);
      end
      m_ready = 1'b1;
      waitRx("bp_cnt", 4, 30);
      for (int k = 0; k < 5; k++) tick();
      checkOutput("bp_nodup", 64'(rxCnt - rxBase), 4);
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("bp_word%0d", k), rxAt(k), {2'd1, 32'hD000_0000 + k});

      // enable dropped mid-burst: burst completes, no new grant
      doReset();
      for (int k = 0; k < 8; k++) applyStimulus(0, 32'hE000_0000 + k);
      tick();
      checkOutput("en_busy", busy, 1);
      enable = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      checkOutput("en_cnt4", 64'(rxCnt - rxBase), 4);
      checkOutput("en_idle", busy, 0);
      checkOutput("en_left", src_empty, 4'b1110);
      enable = 1'b1;
      waitRx("en_cnt8", 8, 30);
      checkOutput("en_word4", rxAt(4), {2'd0, 32'hE000_0004});

      // Async reset mid-burst
      doReset();
      for (int k = 0; k < 4; k++) applyStimulus(3, 32'hF000_0000 + k);
      tick();
      tick();
      checkOutput("ar_pre_valid", m_valid, 1);
      checkOutput("ar_pre_pop", src_shift_out, 4'b1000);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_valid", m_valid, 0);
      checkOutput("ar_data", m_data, 0);
      checkOutput("ar_src", m_src, 0);
      checkOutput("ar_busy", busy, 0);
      checkOutput("ar_pop", src_shift_out, 0);

`ifdef SCHED_STATS_EN
      // Beat counters: count, clear, saturate
      doReset();
      checkOutput("st_rst", stat_beats, 0);
      for (int k = 0; k < 10; k++) applyStimulus(1, k);
      waitRx("st_cnt", 10, 60);
      tick();
      checkOutput("st_ten", stat_beats, 64'h0000_0000_000A_0000);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      checkOutput("st_clr", stat_beats, 0);
      wrPtr[2] = rdPtr[2] + 65540;
      begin
         int k;
         k = 0;
         while (!src_empty[2] && k < 90000) begin
            tick();
            k++;
         end
      end
      tick();
      checkOutput("st_drained", src_empty[2], 1);
      checkOutput("st_sat", stat_beats[47:32], 16'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
